// File: rtl/ps2_key_receiver_if.sv
// ps2_key_receiver_if: bundles the raw PS/2 lines from the keyboard with the
// decoded key outputs handed to the object motion logic.
// master = keyboard/environment side, slave = the receiver.
interface ps2_key_receiver_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keyData;
  logic       keyReady;
  logic       keyExt;
  logic       frameErr;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  keyData,
    input  keyReady,
    input  keyExt,
    input  frameErr
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output keyData,
    output keyReady,
    output keyExt,
    output frameErr
  );
endinterface

// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: turns the PS/2 keyboard serial stream into make-code
// reports (keyData/keyExt with a keyReady strobe). It drops break sequences,
// tracks the E0 extended prefix and pulses frameErr on malformed or stalled
// frames.
// Optional macro PS2_PARITY_CHECK_EN: when defined, frames with bad odd
// parity are rejected. When undefined, the parity bit is captured but does
// not affect acceptance.
module ps2_key_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int READY_CYCLES   = 4
) (
  input  logic              clk,
  input  logic              rst,
  ps2_key_receiver_if.slave bus
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RCW = $clog2(READY_CYCLES + 1);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_GATES = 1'b1;
`else
  localparam bit PARITY_GATES = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic [1:0]     clkSyncQ;
  logic [1:0]     dataSyncQ;
  logic           clkS;
  logic           dataS;

  logic [FCW-1:0] filtCntQ, filtCntD;
  logic           levelQ, levelD;
  logic           fe;

  state_e         stateQ, stateD;
  logic [2:0]     bitCntQ;
  logic [7:0]     byteQ;
  logic           parityQ;
  logic [TCW-1:0] timeoutCntQ;

  logic           brkQ;
  logic           extQ;
  logic [7:0]     keyDataQ;
  logic           keyExtQ;
  logic [RCW-1:0] readyCntQ;
  logic           frameErrQ;

  logic           parityGood;
  logic           parityOk;
  logic           goodFrame;
  logic           badFrame;
  logic           timeoutHit;
  logic           report;

  // Two-flop synchronisers for both asynchronous PS/2 lines; idle level is 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      clkSyncQ  <= 2'b11;
      dataSyncQ <= 2'b11;
    end else begin
      clkSyncQ  <= {clkSyncQ[0], bus.ps2_clk};
      dataSyncQ <= {dataSyncQ[0], bus.ps2_data};
    end
  end

  assign clkS  = clkSyncQ[1];
  assign dataS = dataSyncQ[1];

  // Glitch filter: flip the level only after FILTER_LEN differing samples; a falling flip is fe.
  always_comb begin
    filtCntD = '0;
    levelD   = levelQ;
    fe       = 1'b0;
    if (clkS != levelQ) begin
      if (filtCntQ == FCW'(FILTER_LEN - 1)) begin
        levelD = clkS;
        fe     = levelQ;
      end else begin
        filtCntD = filtCntQ + FCW'(1);
      end
    end
  end

  // Filter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      filtCntQ <= '0;
      levelQ   <= 1'b1;
    end else begin
      filtCntQ <= filtCntD;
      levelQ   <= levelD;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // FSM next-state logic; a timeout overrides everything and abandons the frame.
  always_comb begin
    stateD = stateQ;
    if (timeoutHit) begin
      stateD = IDLE;
    end else if (fe) begin
      case (stateQ)
        IDLE:    if (!dataS) stateD = DATA;
        DATA:    if (bitCntQ == 3'd7) stateD = PARITY;
        PARITY:  stateD = STOP;
        STOP:    stateD = IDLE;
        default: stateD = IDLE;
      endcase
    end
  end

  // FSM outputs: frame verdicts, timeout detection and whether a good frame is reported.
  always_comb begin
    parityGood = ^{byteQ, parityQ};
    parityOk   = parityGood | ~PARITY_GATES;
    goodFrame  = 1'b0;
    badFrame   = 1'b0;
    timeoutHit = 1'b0;
    if (stateQ != IDLE && !fe && timeoutCntQ == TCW'(TIMEOUT_CYCLES)) begin
      timeoutHit = 1'b1;
    end
    if (fe) begin
      case (stateQ)
        IDLE: begin
          if (dataS) badFrame = 1'b1;
        end
        STOP: begin
          if (dataS && parityOk) goodFrame = 1'b1;
          else                   badFrame  = 1'b1;
        end
        default: ;
      endcase
    end
    report = goodFrame && (byteQ != 8'hF0) && (byteQ != 8'hE0) && !brkQ;
  end

  // Frame datapath: bit counter, byte shift-in, parity capture and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bitCntQ     <= '0;
      byteQ       <= '0;
      parityQ     <= 1'b0;
      timeoutCntQ <= '0;
    end else begin
      if (stateQ == IDLE || fe || timeoutHit) begin
        timeoutCntQ <= '0;
      end else begin
        timeoutCntQ <= timeoutCntQ + TCW'(1);
      end
      if (timeoutHit) begin
        byteQ   <= '0;
        bitCntQ <= '0;
      end else if (fe) begin
        case (stateQ)
          IDLE: begin
            if (!dataS) begin
              bitCntQ <= '0;
              byteQ   <= '0;
            end
          end
          DATA: begin
            byteQ[bitCntQ] <= dataS;
            bitCntQ        <= bitCntQ + 3'd1;
          end
          PARITY:  parityQ <= dataS;
          default: ;
        endcase
      end
    end
  end

  // Decoder and output registers: prefix flags, reported key, ready hold and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      brkQ      <= 1'b0;
      extQ      <= 1'b0;
      keyDataQ  <= '0;
      keyExtQ   <= 1'b0;
      readyCntQ <= '0;
      frameErrQ <= 1'b0;
    end else begin
      frameErrQ <= badFrame | timeoutHit;
      if (goodFrame) begin
        if (byteQ == 8'hF0) begin
          brkQ <= 1'b1;
        end else if (byteQ == 8'hE0) begin
          extQ <= 1'b1;
        end else if (brkQ) begin
          brkQ <= 1'b0;
          extQ <= 1'b0;
        end else begin
          keyDataQ <= byteQ;
          keyExtQ  <= extQ;
          extQ     <= 1'b0;
        end
      end
      if (report) begin
        readyCntQ <= RCW'(READY_CYCLES);
      end else if (readyCntQ != '0) begin
        readyCntQ <= readyCntQ - RCW'(1);
      end
    end
  end

  assign bus.keyData  = keyDataQ;
  assign bus.keyExt   = keyExtQ;
  assign bus.keyReady = (readyCntQ != '0);
  assign bus.frameErr = frameErrQ;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb_ps2_key_receiver: table-driven bench for ps2_key_receiver. Each record
// sends one PS/2 frame and states the expected report, ready length and error
// count; hand-written sequences cover timeout and reset mid-frame.
// Bit timing and timeout are scaled down so the run stays short.
module tb_ps2_key_receiver;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 400;
  localparam int READY_CYCLES   = 4;
  localparam int HALF           = 30;
  localparam int QUARTER        = 15;

  typedef struct {
    string      name;
    logic [7:0] code;
    bit         badParity;
    bit         stopBit;
    bit         glitch;
    int         expReadyCycles;
    logic [7:0] expData;
    bit         expExt;
    int         expErrCycles;
  } vec_t;

  logic clk;
  logic rst;
  ps2_key_receiver_if ifc ();

  int   checks;
  int   errors;
  int   readyCycles;
  int   errCycles;
  vec_t vecs[$];

  ps2_key_receiver #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .READY_CYCLES  (READY_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  // 100 MHz system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running totals of keyReady-high and frameErr-high cycles, sampled on the inactive edge.
  always @(negedge clk) begin
    if (ifc.keyReady === 1'b1) readyCycles++;
    if (ifc.frameErr === 1'b1) errCycles++;
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One PS/2 bit: data changes while the clock is high, the falling edge marks the sample.
  task automatic sendBit(input bit b, input bit glitch);
    ifc.ps2_data = b;
    waitClk(QUARTER);
    ifc.ps2_clk = 1'b0;
    waitClk(HALF);
    ifc.ps2_clk = 1'b1;
    if (glitch) begin
      waitClk(12);
      ifc.ps2_clk = 1'b0;
      waitClk(3);
      ifc.ps2_clk = 1'b1;
    end else begin
      waitClk(QUARTER);
    end
  endtask

  task automatic sendFrame(input logic [7:0] code, input bit badParity, input bit stopBit,
                           input bit glitch);
    bit par;
    par = (~^code) ^ badParity;
    sendBit(1'b0, glitch);
    for (int i = 0; i < 8; i++) sendBit(code[i], glitch);
    sendBit(par, glitch);
    sendBit(stopBit, glitch);
    ifc.ps2_data = 1'b1;
    waitClk(10);
  endtask

  task automatic sendPartial(input logic [7:0] code, input int nData);
    sendBit(1'b0, 1'b0);
    for (int i = 0; i < nData; i++) sendBit(code[i], 1'b0);
    ifc.ps2_data = 1'b1;
  endtask

  function automatic vec_t mkVec(input string name, input logic [7:0] code, input bit badParity,
                                 input bit stopBit, input bit glitch, input int expReady,
                                 input logic [7:0] expData, input bit expExt, input int expErr);
    vec_t v;
    v.name           = name;
    v.code           = code;
    v.badParity      = badParity;
    v.stopBit        = stopBit;
    v.glitch         = glitch;
    v.expReadyCycles = expReady;
    v.expData        = expData;
    v.expExt         = expExt;
    v.expErrCycles   = expErr;
    return v;
  endfunction

  // Sends one table record and compares ready length, error pulses and the held key.
  task automatic applyStimulus(input vec_t v);
    int r0;
    int e0;
    r0 = readyCycles;
    e0 = errCycles;
    sendFrame(v.code, v.badParity, v.stopBit, v.glitch);
    checkOutput({v.name, ".readyCycles"}, readyCycles - r0, v.expReadyCycles);
    checkOutput({v.name, ".errCycles"}, errCycles - e0, v.expErrCycles);
    checkOutput({v.name, ".keyData"}, int'(ifc.keyData), int'(v.expData));
    checkOutput({v.name, ".keyExt"}, int'(ifc.keyExt), int'(v.expExt));
  endtask

  initial begin
    int r0;
    int e0;
    checks      = 0;
    errors      = 0;
    readyCycles = 0;
    errCycles   = 0;

    // 0x1C has three ones, so its correct odd parity bit is 0; the corrupted frame carries 1.
    vecs.push_back(mkVec("make1D",   8'h1D, 0, 1, 0, 4, 8'h1D, 0, 0));
    vecs.push_back(mkVec("brkF0",    8'hF0, 0, 1, 0, 0, 8'h1D, 0, 0));
    vecs.push_back(mkVec("brk1D",    8'h1D, 0, 1, 0, 0, 8'h1D, 0, 0));
    vecs.push_back(mkVec("make23",   8'h23, 0, 1, 0, 4, 8'h23, 0, 0));
    vecs.push_back(mkVec("extE0",    8'hE0, 0, 1, 0, 0, 8'h23, 0, 0));
    vecs.push_back(mkVec("ext75",    8'h75, 0, 1, 0, 4, 8'h75, 1, 0));
    vecs.push_back(mkVec("make1B",   8'h1B, 0, 1, 0, 4, 8'h1B, 0, 0));
`ifdef PS2_PARITY_CHECK_EN
    vecs.push_back(mkVec("badPar1C", 8'h1C, 1, 1, 0, 0, 8'h1B, 0, 1));
`else
    vecs.push_back(mkVec("badPar1C", 8'h1C, 1, 1, 0, 4, 8'h1C, 0, 0));
`endif
    vecs.push_back(mkVec("good1C",   8'h1C, 0, 1, 0, 4, 8'h1C, 0, 0));
    vecs.push_back(mkVec("stop0_1B", 8'h1B, 0, 0, 0, 0, 8'h1C, 0, 1));
    vecs.push_back(mkVec("glitch1B", 8'h1B, 0, 1, 1, 4, 8'h1B, 0, 0));
    vecs.push_back(mkVec("extE0b",   8'hE0, 0, 1, 0, 0, 8'h1B, 0, 0));
    vecs.push_back(mkVec("brkF0b",   8'hF0, 0, 1, 0, 0, 8'h1B, 0, 0));
    vecs.push_back(mkVec("rel75",    8'h75, 0, 1, 0, 0, 8'h1B, 0, 0));
    vecs.push_back(mkVec("after1D",  8'h1D, 0, 1, 0, 4, 8'h1D, 0, 0));

    rst          = 1'b1;
    ifc.ps2_clk  = 1'b1;
    ifc.ps2_data = 1'b1;
    waitClk(5);
    @(negedge clk);
    checkOutput("reset.keyData",  int'(ifc.keyData),  0);
    checkOutput("reset.keyReady", int'(ifc.keyReady), 0);
    checkOutput("reset.keyExt",   int'(ifc.keyExt),   0);
    checkOutput("reset.frameErr", int'(ifc.frameErr), 0);
    rst = 1'b0;
    waitClk(20);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Stalled frame after an E0 prefix: one error pulse, then the prefix still applies.
    sendFrame(8'hE0, 1'b0, 1'b1, 1'b0);
    r0 = readyCycles;
    e0 = errCycles;
    sendPartial(8'h23, 4);
    waitClk(TIMEOUT_CYCLES + 100);
    checkOutput("timeout.errCycles",   errCycles - e0,   1);
    checkOutput("timeout.readyCycles", readyCycles - r0, 0);
    applyStimulus(mkVec("postTimeout23", 8'h23, 0, 1, 0, 4, 8'h23, 1, 0));

    // Reset in the middle of a frame clears outputs and the pending E0 prefix.
    sendFrame(8'hE0, 1'b0, 1'b1, 1'b0);
    sendPartial(8'h75, 5);
    rst = 1'b1;
    waitClk(3);
    @(negedge clk);
    checkOutput("midReset.keyData",  int'(ifc.keyData),  0);
    checkOutput("midReset.keyReady", int'(ifc.keyReady), 0);
    checkOutput("midReset.keyExt",   int'(ifc.keyExt),   0);
    checkOutput("midReset.frameErr", int'(ifc.frameErr), 0);
    rst = 1'b0;
    waitClk(20);
    applyStimulus(mkVec("postReset1D", 8'h1D, 0, 1, 0, 4, 8'h1D, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
